// File: rtl/bp_cce_mem_credit_tracker.sv
// Credit counter for outstanding CCE memory commands, with sticky boundary
// error flags and a fence handshake that completes once every command has been answered.
module bp_cce_mem_credit_tracker #(
   parameter int mem_noc_max_credits_p = 8,
   localparam int credit_width_lp = $clog2(mem_noc_max_credits_p+1)
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       mem_cmd_v_i,
   input  logic                       mem_resp_yumi_i,
   input  logic                       fence_v_i,
   output logic                       fence_ready_o,
   output logic                       fence_done_o,
   output logic                       credits_empty_o,
   output logic                       credits_full_o,
   output logic [credit_width_lp-1:0] credit_count_o,
   output logic                       overflow_err_o,
   output logic                       underflow_err_o
);

   localparam logic [credit_width_lp-1:0] max_lp  = credit_width_lp'(mem_noc_max_credits_p);
   localparam logic [credit_width_lp-1:0] zero_lp = '0;
   localparam logic [credit_width_lp-1:0] one_lp  = credit_width_lp'(1);

   typedef enum logic [1:0] {
      e_ready = 2'd0,
      e_wait  = 2'd1,
      e_done  = 2'd2
   } fence_state_e;

   fence_state_e               state_reg, state_next;
   logic [credit_width_lp-1:0] count_reg, count_next;
   logic                       overflow_reg, overflow_next;
   logic                       underflow_reg, underflow_next;

   // Simultaneous cmd and yumi cancel out, so only the lone cases touch the count.
   always_comb begin
      count_next     = count_reg;
      overflow_next  = overflow_reg;
      underflow_next = underflow_reg;
      if (mem_cmd_v_i && !mem_resp_yumi_i) begin
         if (count_reg == zero_lp) begin
            underflow_next = 1'b1;
         end else begin
            count_next = count_reg - one_lp;
         end
      end else if (mem_resp_yumi_i && !mem_cmd_v_i) begin
         if (count_reg == max_lp) begin
            overflow_next = 1'b1;
         end else begin
            count_next = count_reg + one_lp;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         e_ready: begin
            if (fence_v_i) begin
               state_next = (count_reg == max_lp) ? e_done : e_wait;
            end
         end
         e_wait: begin
            if (count_reg == max_lp) begin
               state_next = e_done;
            end
         end
         e_done:  state_next = e_ready;
         default: state_next = e_ready;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg     <= e_ready;
         count_reg     <= max_lp;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         overflow_reg  <= overflow_next;
         underflow_reg <= underflow_next;
      end
   end

   assign credit_count_o  = count_reg;
   assign credits_empty_o = (count_reg == zero_lp);
   assign credits_full_o  = (count_reg == max_lp);
   assign fence_ready_o   = (state_reg == e_ready);
   assign fence_done_o    = (state_reg == e_done);
   assign overflow_err_o  = overflow_reg;
   assign underflow_err_o = underflow_reg;

endmodule

// File: tb/tb_bp_cce_mem_credit_tracker.sv
// Randomized and directed bench for the memory credit tracker, checked against
// a behavioural model of credits, error flags and fence completion.
module tb_bp_cce_mem_credit_tracker;

   localparam int max_lp = 8;

   logic       clk_i = 1'b0;
   logic       reset_n_i = 1'b0;
   logic       mem_cmd_v_i = 1'b0;
   logic       mem_resp_yumi_i = 1'b0;
   logic       fence_v_i = 1'b0;
   logic       fence_ready_o, fence_done_o, credits_empty_o, credits_full_o;
   logic [3:0] credit_count_o;
   logic       overflow_err_o, underflow_err_o;

   int checks_cnt = 0;
   int errors_cnt = 0;

   // Model: credits as an integer, fence as "pending" plus a "done due now" flag.
   int m_credits;
   bit m_of, m_uf;
   bit m_fence_pending, m_done_now;

   bp_cce_mem_credit_tracker #(.mem_noc_max_credits_p(max_lp)) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .mem_cmd_v_i(mem_cmd_v_i), .mem_resp_yumi_i(mem_resp_yumi_i), .fence_v_i(fence_v_i),
      .fence_ready_o(fence_ready_o), .fence_done_o(fence_done_o),
      .credits_empty_o(credits_empty_o), .credits_full_o(credits_full_o),
      .credit_count_o(credit_count_o),
      .overflow_err_o(overflow_err_o), .underflow_err_o(underflow_err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input int obs, input int exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      int outstanding;
      outstanding = max_lp - m_credits;
      check_val({tag, ".count"}, credit_count_o, m_credits);
      check_val({tag, ".empty"}, credits_empty_o, (m_credits == 0));
      check_val({tag, ".full"},  credits_full_o, (outstanding == 0));
      check_val({tag, ".ready"}, fence_ready_o, !(m_fence_pending || m_done_now));
      check_val({tag, ".done"},  fence_done_o, m_done_now);
      check_val({tag, ".of"},    overflow_err_o, m_of);
      check_val({tag, ".uf"},    underflow_err_o, m_uf);
   endtask

   task automatic model_reset();
      m_credits = max_lp;
      m_of = 0; m_uf = 0;
      m_fence_pending = 0; m_done_now = 0;
   endtask

   // Applies one clock of inputs to the model, using the credit state seen before the edge.
   task automatic model_edge(input bit c, input bit y, input bit f);
      bit nothing_outstanding;
      nothing_outstanding = (m_credits == max_lp);
      if (m_done_now) begin
         m_done_now = 0;
      end else if (!m_fence_pending) begin
         if (f) begin
            if (nothing_outstanding) m_done_now = 1;
            else m_fence_pending = 1;
         end
      end else if (nothing_outstanding) begin
         m_fence_pending = 0;
         m_done_now = 1;
      end
      if (c && !y) begin
         if (m_credits == 0) m_uf = 1;
         else m_credits = m_credits - 1;
      end else if (y && !c) begin
         if (m_credits == max_lp) m_of = 1;
         else m_credits = m_credits + 1;
      end
   endtask

   task automatic step(input bit c, input bit y, input bit f, input string tag);
      @(negedge clk_i);
      mem_cmd_v_i = c; mem_resp_yumi_i = y; fence_v_i = f;
      @(posedge clk_i);
      model_edge(c, y, f);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      #2;
      reset_n_i = 1'b0;
      model_reset();
      #1;
      check_all(tag);
      @(negedge clk_i);
      mem_cmd_v_i = 0; mem_resp_yumi_i = 0; fence_v_i = 0;
      reset_n_i = 1'b1;
      #1;
      check_all({tag, ".rel"});
   endtask

   initial begin
      model_reset();
      #12;
      check_all("reset");
      do_reset("reset");

      for (int i = 0; i < 8; i++) step(1, 0, 0, "drain");
      for (int i = 0; i < 8; i++) step(0, 1, 0, "refill");

      for (int i = 0; i < 8; i++) step(1, 0, 0, "drain2");
      for (int i = 0; i < 3; i++) step(1, 1, 0, "both_at_0");
      for (int i = 0; i < 8; i++) step(0, 1, 0, "refill2");
      for (int i = 0; i < 3; i++) step(1, 1, 0, "both_at_max");

      for (int i = 0; i < 8; i++) step(1, 0, 0, "drain3");
      step(1, 0, 0, "underflow");
      do_reset("rst_uf");
      step(0, 1, 0, "overflow");
      for (int i = 0; i < 8; i++) step(1, 0, 0, "drain4");
      step(1, 0, 0, "underflow2");
      for (int i = 0; i < 20; i++) step(0, 0, 0, "sticky");
      do_reset("rst_err");

      for (int i = 0; i < 3; i++) step(1, 0, 0, "fence_issue");
      step(0, 0, 1, "fence_req");
      for (int i = 0; i < 2; i++) step(0, 0, 0, "fence_wait");
      for (int i = 0; i < 3; i++) step(0, 1, 0, "fence_yumi");
      for (int i = 0; i < 3; i++) step(0, 0, 0, "fence_done");

      step(0, 0, 1, "idle_fence");
      for (int i = 0; i < 2; i++) step(0, 0, 0, "idle_done");

      for (int i = 0; i < 2; i++) step(1, 0, 0, "mid_issue");
      step(0, 0, 1, "mid_fence");
      step(0, 0, 0, "mid_wait");
      do_reset("mid_reset");
      for (int i = 0; i < 3; i++) step(0, 0, 0, "mid_after");

      for (int i = 0; i < 400; i++) begin
         bit c, y, f;
         c = ($urandom_range(0, 99) < 45);
         y = ($urandom_range(0, 99) < 45);
         f = ($urandom_range(0, 99) < 10);
         // Keep boundary errors rare so the random phase exercises normal traffic.
         if (c && !y && m_credits == 0 && $urandom_range(0, 9) != 0) c = 0;
         if (y && !c && m_credits == max_lp && $urandom_range(0, 9) != 0) y = 0;
         step(c, y, f, "rand");
         if ($urandom_range(0, 99) == 0) do_reset("rand_reset");
      end

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
